// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - core data-port bus between the RISC-V core and the data-memory responder
interface data_mem_resp_if;
  logic        ena_rd;
  logic        ena_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        fault;

  modport master (
    output ena_rd, ena_wr, addr, wdata, funct3,
    input  rdata, ready, busy, fault
  );

  modport slave (
    input  ena_rd, ena_wr, addr, wdata, funct3,
    output rdata, ready, busy, fault
  );
endinterface

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - word RAM responder with byte-lane stores, formatted loads and a wait-state FSM
module data_mem_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic            CLOCK,
  input logic            RST,
  data_mem_resp_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic              op_wr_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [2**ADDR_W];

  logic              idle;
  logic              req;
  logic              f3_ok;
  logic              misaligned;
  logic              req_fault;
  logic              commit;

  logic              acc_wr;
  logic [ADDR_W+1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [2:0]        acc_f3;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;
  logic [3:0]        st_be;

  assign idle = (state == S_IDLE);
  assign req  = bus.ena_rd | bus.ena_wr;

  // With both enables high the request is a store, so ena_wr alone picks the op.
  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    if (bus.ena_wr)
      f3_ok = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
      misaligned = 1'b1;
    if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
      misaligned = 1'b1;
    req_fault = !f3_ok || misaligned;
  end

  // Zero wait states access the RAM on the accepting edge, straight from the bus.
  assign acc_wr    = idle ? bus.ena_wr : op_wr_q;
  assign acc_addr  = idle ? bus.addr[ADDR_W+1:0] : addr_q;
  assign acc_wdata = idle ? bus.wdata : wdata_q;
  assign acc_f3    = idle ? bus.funct3 : funct3_q;
  assign acc_idx   = acc_addr[ADDR_W+1:2];

  assign rd_word  = mem[acc_idx];
  assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};

  always_comb begin
    ld_data = rd_word;
    case (acc_f3)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'd0, rd_shift[7:0]};
      3'b101:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << acc_addr[1:0];
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (req_fault)
            state_nxt = S_ERR;
          else if (WAIT_STATES == 0)
            state_nxt = S_RESP;
          else
            state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (cnt == 3'd1) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign commit = (state_nxt == S_RESP);

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (idle && req) begin
        op_wr_q  <= bus.ena_wr;
        addr_q   <= bus.addr[ADDR_W+1:0];
        wdata_q  <= bus.wdata;
        funct3_q <= bus.funct3;
        cnt      <= 3'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 3'd1;
      end
      if (state_nxt == S_ERR)
        rdata_q <= 32'd0;
      else if (commit && !acc_wr)
        rdata_q <= ld_data;
    end
  end

  // RAM has no reset; a reset on the committing edge still suppresses the write.
  always_ff @(posedge CLOCK) begin
    if (!RST && commit && acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i])
          mem[acc_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == S_RESP) || (state == S_ERR);
  assign bus.busy  = !idle;
  assign bus.fault = (state == S_ERR);

endmodule
